// File: rtl/inst_queue_pkg.sv
// Shared definitions for the Fetch->Decode instruction queue.
// Entry layout: {nextpc[63:32], instruc[31:0]}.
package inst_queue_pkg;

    localparam int unsigned IQ_DEPTH   = 4;
    localparam int unsigned IQ_ENTRY_W = 64;
    localparam logic [31:0] NOP_WORD   = 32'h0;

    typedef struct packed {
        logic [31:0] nextpc;
        logic [31:0] instruc;
    } iq_entry_t;

endpackage

// File: rtl/iq_storage.sv
// Instruction queue register file: one sync write port, one async read port.
// Data is not reset; validity is tracked by the queue occupancy.
module iq_storage
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned W     = IQ_ENTRY_W
) (
    input  logic             clock,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between Fetch and Decode with flush on taken
// control transfers and a sticky overflow flag.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = IQ_DEPTH,
    parameter int unsigned PTR_W     = 2,
    parameter bit          DROP_ZERO = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             if_q_push,
    input  logic [31:0]      if_q_instruc,
    input  logic [31:0]      if_q_nextpc,
    output logic             q_if_full,
    output logic             q_if_afull,
    output logic             q_id_valid,
    output logic [31:0]      q_id_instruc,
    output logic [31:0]      q_id_nextpc,
    input  logic             id_q_ready,
    input  logic             id_q_flush,
    output logic             q_overflow,
    output logic [PTR_W:0]   q_count
);

    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AFULL_CNT = (PTR_W+1)'(DEPTH - 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             bubble;
    logic             push_ok;
    logic             pop_ok;
    iq_entry_t        wr_entry;
    iq_entry_t        rd_entry;

    assign bubble  = DROP_ZERO && (if_q_instruc == NOP_WORD);
    assign push_ok = if_q_push & ~q_if_full & ~bubble & ~id_q_flush;
    assign pop_ok  = id_q_ready & q_id_valid & ~id_q_flush;

    assign wr_entry.nextpc  = if_q_nextpc;
    assign wr_entry.instruc = if_q_instruc;

    iq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (IQ_ENTRY_W)
    ) u_storage (
        .clock (clock),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (id_q_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A real (non-bubble) push refused only because the queue is full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (if_q_push & q_if_full & ~bubble & ~id_q_flush) begin
            overflow <= 1'b1;
        end
    end

    assign q_if_full    = (count == FULL_CNT);
    assign q_if_afull   = (count >= AFULL_CNT);
    assign q_id_valid   = (count != '0);
    assign q_id_instruc = q_id_valid ? rd_entry.instruc : NOP_WORD;
    assign q_id_nextpc  = q_id_valid ? rd_entry.nextpc  : NOP_WORD;
    assign q_overflow   = overflow;
    assign q_count      = count;

endmodule
